// File: rtl/serdes_pkg.sv
// Shared definitions for the serial transmit/receive pair.
// Holds the legacy-compatible FSM state encodings and the bit-order constant
// that both the transmitter (piso_serializer) and the matching receiver use.
package serdes_pkg;

  // FSM state encodings, kept as plain constants so older code can still
  // compare against them directly.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Words travel MSB first. The receiver shifts left and takes the serial bit
  // into its LSB, so the first bit it receives ends up as the MSB of the word.
  localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel word input plus serial bit output of the PISO transmitter.
//   in_valid/in_ready/in_data        : word handshake (word accepted when both are high)
//   sout/sout_valid/sout_ready       : serial bit handshake (bit consumed when both are high)
//   sout_first/sout_last             : current bit is the MSB / LSB of its word
// Modports:
//   slave  : the serializer's view
//   master : the producer/consumer (environment) view
interface piso_serializer_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_first;
  logic             sout_last;

  modport slave (
    input  in_valid, in_data, sout_ready,
    output in_ready, sout, sout_valid, sout_first, sout_last
  );

  modport master (
    output in_valid, in_data, sout_ready,
    input  in_ready, sout, sout_valid, sout_first, sout_last
  );

endinterface

// File: rtl/piso_shift_core.sv
// WIDTH-bit shift register used by the PISO transmitter.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset (clears q)
//   load     : q <= din (takes priority over shift)
//   shift    : q <= q shifted left by one, zero into the LSB
//   din      : parallel load value
//   q        : register contents
// With neither load nor shift asserted the register holds.
module piso_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter.
// Accepts WIDTH-bit words on a valid/ready port and sends them MSB first, one
// bit per accepted serial beat. A one-word holding buffer lets the next word
// follow the current one with no idle bit slot between them.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset (discards any partial word and the hold buffer)
//   bus  : piso_serializer_if.slave (word input, serial output, first/last markers)
//   busy : a word is being shifted or is waiting in the hold buffer
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_serializer_if.slave      bus,
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sh;

  logic             accept;
  logic             xfer;
  logic             last_bit;
  logic             bypass;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_din;

  // in_ready depends only on registered state, so there is no combinational
  // path from sout_ready to in_ready.
  assign bus.in_ready   = !hold_full;
  assign accept         = bus.in_valid && !hold_full;
  assign bus.sout_valid = (state == ST_SHIFT);
  assign xfer           = bus.sout_valid && bus.sout_ready;
  assign last_bit       = (cnt == CNT_LAST);
  assign bus.sout       = sh[WIDTH-1];
  assign bus.sout_first = bus.sout_valid && (cnt == '0);
  assign bus.sout_last  = bus.sout_valid && last_bit;
  assign busy           = (state != ST_IDLE) || hold_full;

  // Shift register control. On the last bit the next word comes from the hold
  // buffer first, else straight from the input (bypass); if neither is
  // available the register is shifted once more so it drains to zero.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = bus.in_data;
    bypass   = 1'b0;
    if (state == ST_IDLE) begin
      sh_load = accept;
    end else if (xfer) begin
      if (!last_bit) begin
        sh_shift = 1'b1;
      end else if (hold_full) begin
        sh_load = 1'b1;
        sh_din  = hold;
      end else if (accept) begin
        sh_load = 1'b1;
        bypass  = 1'b1;
      end else begin
        sh_shift = 1'b1;
      end
    end
  end

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .q     (sh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (accept) begin
          state <= ST_SHIFT;
          cnt   <= '0;
        end
      end else if (xfer) begin
        if (!last_bit) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          if (!hold_full && !accept) begin
            state <= ST_IDLE;
          end
        end
      end

      // Hold buffer drains into the shifter on the last bit of the current word.
      if (hold_full && xfer && last_bit) begin
        hold_full <= 1'b0;
      end

      // A word accepted while shifting waits here unless it went straight
      // into the shifter on this edge. Accept implies !hold_full, so this
      // never collides with the drain above.
      if ((state == ST_SHIFT) && accept && !bypass) begin
        hold      <= bus.in_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
